// File: rtl/lvds_frame_serializer_if.sv
// Parallel word stream feeding the LVDS frame serializer.
// The source drives s_data/s_valid; the serializer answers with s_ready
// only in the cycle where it is prepared to take the next word.
interface lvds_frame_serializer_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/lvds_frame_serializer.sv
// LVDS frame serializer: after tx_enable it sends a block of training words
// so the far end can align, then streams parallel words MSB first with a
// 50% duty frame clock. Missing data at a word boundary is replaced by the
// idle pattern and counted as an underrun.
module lvds_frame_serializer #(
   parameter int                    DATA_WIDTH    = 16,
   parameter int                    TRAIN_WORDS   = 8,
   parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DATA_WIDTH'(16'h00FF),
   parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN  = DATA_WIDTH'(16'h0000)
) (
   input  logic                  bit_clk,
   input  logic                  clk_reset,
   input  logic                  tx_enable,
   lvds_frame_serializer_if.slave s_if,
   output logic                  dout,
   output logic                  fclk_out,
   output logic                  frame_start,
   output logic                  busy,
   output logic                  underrun,
   output logic [7:0]            underrun_cnt
);

   localparam int             CNT_W      = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(DATA_WIDTH / 2);
   localparam logic [7:0]     LAST_TRAIN = 8'(TRAIN_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRAIN,
      ST_DATA
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
   logic [CNT_W-1:0]      bitCntInc;
   logic [DATA_WIDTH-1:0] shiftReg_q, shiftReg_d;
   logic                  fclk_q, fclk_d;
   logic                  frameStart_q, frameStart_d;
   logic                  underrun_q, underrun_d;
   logic [7:0]            underrunCnt_q, underrunCnt_d;
   logic [7:0]            trainCnt_q, trainCnt_d;
   logic                  sReady;

   // State and datapath registers; reset aborts any word in flight.
   always_ff @(posedge bit_clk or posedge clk_reset) begin
      if (clk_reset) begin
         state_q       <= ST_IDLE;
         bitCnt_q      <= '0;
         shiftReg_q    <= '0;
         fclk_q        <= 1'b0;
         frameStart_q  <= 1'b0;
         underrun_q    <= 1'b0;
         underrunCnt_q <= '0;
         trainCnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         bitCnt_q      <= bitCnt_d;
         shiftReg_q    <= shiftReg_d;
         fclk_q        <= fclk_d;
         frameStart_q  <= frameStart_d;
         underrun_q    <= underrun_d;
         underrunCnt_q <= underrunCnt_d;
         trainCnt_q    <= trainCnt_d;
      end
   end

   // Next state: shift within a word, decide what to load only at the boundary.
   always_comb begin
      state_d       = state_q;
      bitCnt_d      = bitCnt_q;
      shiftReg_d    = shiftReg_q;
      fclk_d        = fclk_q;
      frameStart_d  = 1'b0;
      underrun_d    = 1'b0;
      underrunCnt_d = underrunCnt_q;
      trainCnt_d    = trainCnt_q;
      sReady        = 1'b0;
      bitCntInc     = bitCnt_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            bitCnt_d   = '0;
            shiftReg_d = '0;
            fclk_d     = 1'b0;
            if (tx_enable) begin
               state_d      = ST_TRAIN;
               shiftReg_d   = TRAIN_PATTERN;
               fclk_d       = 1'b1;
               frameStart_d = 1'b1;
               trainCnt_d   = '0;
            end
         end
         ST_TRAIN, ST_DATA: begin
            if (bitCnt_q != LAST_BIT) begin
               bitCnt_d   = bitCntInc;
               shiftReg_d = {shiftReg_q[DATA_WIDTH-2:0], 1'b0};
               fclk_d     = (bitCntInc < HALF_BIT);
            end else if (!tx_enable) begin
               state_d    = ST_IDLE;
               bitCnt_d   = '0;
               shiftReg_d = '0;
               fclk_d     = 1'b0;
            end else begin
               bitCnt_d     = '0;
               fclk_d       = 1'b1;
               frameStart_d = 1'b1;
               if ((state_q == ST_TRAIN) && (trainCnt_q != LAST_TRAIN)) begin
                  trainCnt_d = trainCnt_q + 8'd1;
                  shiftReg_d = TRAIN_PATTERN;
               end else begin
                  state_d = ST_DATA;
                  sReady  = 1'b1;
                  if (s_if.s_valid) begin
                     shiftReg_d = s_if.s_data;
                  end else begin
                     shiftReg_d = IDLE_PATTERN;
                     underrun_d = 1'b1;
                     if (underrunCnt_q != 8'hFF) begin
                        underrunCnt_d = underrunCnt_q + 8'd1;
                     end
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign s_if.s_ready = sReady;
   assign dout         = shiftReg_q[DATA_WIDTH-1];
   assign fclk_out     = fclk_q;
   assign frame_start  = frameStart_q;
   assign busy         = (state_q != ST_IDLE);
   assign underrun     = underrun_q;
   assign underrun_cnt = underrunCnt_q;

endmodule

// File: doc/lvds_frame_serializer.md
LVDS_FRAME_SERIALIZER -- requirements
Module: lvds_frame_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bits per serial word (even, 4..32).
REQ-002 SHALL have parameter TRAIN_WORDS, default 8, training words sent after enable (1..255).
REQ-003 SHALL have parameter TRAIN_PATTERN, default 16'h00FF (DATA_WIDTH bits), alignment word for the far-end deserializer.
REQ-004 SHALL have parameter IDLE_PATTERN, default 16'h0000 (DATA_WIDTH bits), word sent on underrun.
REQ-005 bit_clk  in  1  sole clock; all logic on rising edge.
REQ-006 clk_reset  in  1  asynchronous, active-high reset.
REQ-007 tx_enable  in  1  level request to transmit.
REQ-008 s_data  in  DATA_WIDTH  parallel word to serialize.
REQ-009 s_valid  in  1  s_data valid.
REQ-010 s_ready  out  1  word accepted in a cycle where s_valid and s_ready are both 1.
REQ-011 dout  out  1  serial data, MSB first.
REQ-012 fclk_out  out  1  frame clock, one period per word.
REQ-013 frame_start  out  1  one-cycle pulse coincident with bit 0 (MSB) of each word on dout.
REQ-014 busy  out  1  high in TRAIN and DATA states.
REQ-015 underrun  out  1  one-cycle pulse when IDLE_PATTERN is substituted.
REQ-016 underrun_cnt  out  8  saturating count of underruns.

Function
REQ-017 SHALL use a bit counter bit_cnt 0..DATA_WIDTH-1, wrapping to 0 after DATA_WIDTH-1; cycle with bit_cnt==DATA_WIDTH-1 is the word boundary.
REQ-018 SHALL implement states IDLE, TRAIN, DATA.
REQ-019 IDLE: dout=0, fclk_out=0, bit_cnt held at 0, s_ready=0, busy=0.
REQ-020 IDLE->TRAIN when tx_enable sampled 1; next cycle bit_cnt=0 and TRAIN_PATTERN MSB on dout.
REQ-021 TRAIN sends exactly TRAIN_WORDS consecutive TRAIN_PATTERN words, then moves to DATA at the boundary of the last training word.
REQ-022 s_ready SHALL be 1 only in the word-boundary cycle in DATA state, or in the last training word's boundary, and only when tx_enable=1; otherwise 0.
REQ-023 A word accepted at a boundary SHALL appear on dout starting the next cycle (MSB at bit_cnt=0), i.e. 1-cycle latency; full word spans DATA_WIDTH cycles.
REQ-024 If s_ready=1 and s_valid=0, next word SHALL be IDLE_PATTERN, underrun pulses 1 cycle at bit 0 of that word, underrun_cnt increments, saturating at 255.
REQ-025 fclk_out SHALL be 1 for bit_cnt 0..DATA_WIDTH/2-1 and 0 for DATA_WIDTH/2..DATA_WIDTH-1 (50% duty) in TRAIN and DATA.
REQ-026 dout, fclk_out, frame_start SHALL be registered outputs, mutually aligned in the same cycle.
REQ-027 tx_enable=0 in TRAIN or DATA SHALL be acted on only at a word boundary: current word completes, no word accepted, state->IDLE next cycle.
REQ-028 tx_enable toggling mid-word SHALL NOT truncate a word or shift fclk_out phase.
REQ-029 Re-enable from IDLE SHALL always restart full TRAIN sequence.
REQ-030 s_data changes while s_ready=0 SHALL have no effect on dout.

Reset
REQ-031 clk_reset=1 SHALL immediately force state IDLE, bit_cnt=0, shift register 0, dout=0, fclk_out=0, frame_start=0, s_ready=0, busy=0, underrun=0, underrun_cnt=0.
REQ-032 Reset asserted mid-word SHALL abort the word; after release block stays IDLE until tx_enable sampled 1.

Verification
REQ-033 Defaults, tx_enable=1, s_valid=0 held -> 8 words 16'h00FF, fclk_out 8 high/8 low each, then IDLE_PATTERN with underrun pulse each word, underrun_cnt 1,2,3...
REQ-034 After training, s_valid=1 with 16'hA5C3 then 16'h1234 -> dout bits 1010010111000011 then 0001001000110100, s_ready pulses exactly at boundaries, frame_start at each MSB.
REQ-035 tx_enable dropped at bit_cnt=5 of a data word -> word completes all 16 bits, no s_ready at that boundary, busy=0 and dout=0 next cycle.
REQ-036 clk_reset pulsed at bit_cnt=7 during TRAIN -> all outputs 0 same cycle; re-enable gives full 8 training words again.
REQ-037 300 consecutive underruns -> underrun_cnt stops at 255; underrun still pulses.
REQ-038 TRAIN_WORDS=1, DATA_WIDTH=8 -> one training word, s_ready at its boundary, first data word immediately follows, fclk_out 4 high/4 low.
